// File: rtl/instr_decode_stage.sv
// Registered MIPS instruction decode stage with a valid/ready handshake.
// Splits the instruction word into its fields, classifies it as R/I/J,
// extends the immediate to XLEN bits and presents the result one cycle
// later through a two-entry skid buffer (MAIN drives the outputs, SKID
// catches the one extra entry accepted while MAIN is stalled).
module instr_decode_stage #(
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [5:0]          out_opcode,
    output logic [4:0]          out_rs,
    output logic [4:0]          out_rt,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_shamt,
    output logic [5:0]          out_funct,
    output logic [XLEN-1:0]     out_imm_ext,
    output logic [25:0]         out_jtarget,
    output logic [1:0]          out_type,
    output logic [PC_WIDTH-1:0] out_pc
);

    localparam logic [1:0] TYPE_R = 2'b00;
    localparam logic [1:0] TYPE_I = 2'b01;
    localparam logic [1:0] TYPE_J = 2'b10;

    // One fully decoded instruction together with its PC.
    typedef struct packed {
        logic [5:0]          opcode;
        logic [4:0]          rs;
        logic [4:0]          rt;
        logic [4:0]          rd;
        logic [4:0]          shamt;
        logic [5:0]          funct;
        logic [XLEN-1:0]     imm_ext;
        logic [25:0]         jtarget;
        logic [1:0]          itype;
        logic [PC_WIDTH-1:0] pc;
    } entry_t;

    entry_t dec;
    entry_t main_q;
    entry_t skid_q;
    logic   main_valid;
    logic   skid_valid;

    // SKID is only ever occupied when MAIN is full, so "skid empty" is
    // exactly "room for one more"; it comes straight from a flop.
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;

    // Combinational decode of the incoming word; every field is extracted
    // regardless of the instruction type.
    always_comb begin
        dec         = '0;
        dec.opcode  = in_instr[31:26];
        dec.rs      = in_instr[25:21];
        dec.rt      = in_instr[20:16];
        dec.rd      = in_instr[15:11];
        dec.shamt   = in_instr[10:6];
        dec.funct   = in_instr[5:0];
        dec.jtarget = in_instr[25:0];
        dec.pc      = in_pc;
        case (in_instr[31:26])
            6'h00:        dec.itype = TYPE_R;
            6'h02, 6'h03: dec.itype = TYPE_J;
            default:      dec.itype = TYPE_I;
        endcase
        case (in_instr[31:26])
            6'h0C, 6'h0D, 6'h0E: dec.imm_ext = XLEN'(in_instr[15:0]);
            default:             dec.imm_ext = XLEN'($signed(in_instr[15:0]));
        endcase
    end

    // Occupancy and data movement: fill MAIN first, spill into SKID only
    // when MAIN is stalled, and refill MAIN from SKID before taking new input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (out_ready) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end
        end else if (!main_valid || out_ready) begin
            main_valid <= in_valid;
            if (in_valid) begin
                main_q <= dec;
            end
        end else if (in_valid) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign out_opcode  = main_q.opcode;
    assign out_rs      = main_q.rs;
    assign out_rt      = main_q.rt;
    assign out_rd      = main_q.rd;
    assign out_shamt   = main_q.shamt;
    assign out_funct   = main_q.funct;
    assign out_imm_ext = main_q.imm_ext;
    assign out_jtarget = main_q.jtarget;
    assign out_type    = main_q.itype;
    assign out_pc      = main_q.pc;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed scenarios followed by
// randomized traffic compared against a queue-based reference model.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;

    logic        in_ready, out_valid;
    logic [5:0]  out_opcode, out_funct;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [31:0] out_imm_ext;
    logic [25:0] out_jtarget;
    logic [1:0]  out_type;
    logic [31:0] out_pc;

    logic        w_in_ready, w_out_valid;
    logic [5:0]  w_opcode, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
    logic [63:0] w_imm_ext;
    logic [25:0] w_jtarget;
    logic [1:0]  w_type;
    logic [31:0] w_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_decode_stage #(.XLEN(32), .PC_WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_funct(out_funct), .out_imm_ext(out_imm_ext),
        .out_jtarget(out_jtarget), .out_type(out_type), .out_pc(out_pc)
    );

    instr_decode_stage #(.XLEN(64), .PC_WIDTH(32)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_opcode(w_opcode), .out_rs(w_rs), .out_rt(w_rt), .out_rd(w_rd),
        .out_shamt(w_shamt), .out_funct(w_funct), .out_imm_ext(w_imm_ext),
        .out_jtarget(w_jtarget), .out_type(w_type), .out_pc(w_pc)
    );

    // Reference classification from the opcode number.
    function automatic logic [1:0] ref_type(input logic [31:0] ins);
        int op;
        op = int'(ins >> 26);
        if (op == 0) return 2'b00;
        if (op == 2 || op == 3) return 2'b10;
        return 2'b01;
    endfunction

    // Reference immediate as a 64-bit two's-complement number.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins);
        longint v;
        int     op;
        op = int'(ins >> 26);
        v  = longint'(ins & 32'hFFFF);
        if (!(op >= 12 && op <= 14) && v >= 32768) v = v - 65536;
        return 64'(v);
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Sends one instruction into an empty stage and stops at the negedge
    // where it is presented on the outputs.
    task automatic present(input logic [31:0] ins, input logic [31:0] pc);
        drive(1'b1, ins, pc, 1'b1, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_hs: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
        end
        checks++;
        if ({out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct, out_imm_ext, out_jtarget, out_type, out_pc} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_fields: got nonzero data expected all zero");
        end
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_rtype;
        drive(1'b1, 32'h014B4820, 32'h00400000, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rtype_latency: got valid=%b expected 0", out_valid);
        end
        next_cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_type !== 2'b00 || out_opcode !== 6'd0) begin
            failures++;
            $display("[TB] FAIL rtype_class: got valid=%b type=%b op=%h expected 1 00 00", out_valid, out_type, out_opcode);
        end
        checks++;
        if (out_rs !== 5'd10 || out_rt !== 5'd11 || out_rd !== 5'd9 || out_shamt !== 5'd0 || out_funct !== 6'h20) begin
            failures++;
            $display("[TB] FAIL rtype_fields: got rs=%0d rt=%0d rd=%0d sh=%0d fn=%h expected 10 11 9 0 20",
                     out_rs, out_rt, out_rd, out_shamt, out_funct);
        end
        checks++;
        if (out_pc !== 32'h00400000) begin
            failures++;
            $display("[TB] FAIL rtype_pc: got %h expected 00400000", out_pc);
        end
        next_cycle();
    endtask

    task automatic test_imm;
        present(32'h2108FFFF, 32'h10);
        checks++;
        if (out_imm_ext !== 32'hFFFFFFFF || out_type !== 2'b01) begin
            failures++;
            $display("[TB] FAIL addi_imm: got imm=%h type=%b expected FFFFFFFF 01", out_imm_ext, out_type);
        end
        checks++;
        if (w_imm_ext !== 64'hFFFFFFFFFFFFFFFF) begin
            failures++;
            $display("[TB] FAIL addi_imm64: got %h expected FFFFFFFFFFFFFFFF", w_imm_ext);
        end
        next_cycle();
        present(32'h3408FFFF, 32'h14);
        checks++;
        if (out_imm_ext !== 32'h0000FFFF || out_type !== 2'b01) begin
            failures++;
            $display("[TB] FAIL ori_imm: got imm=%h type=%b expected 0000FFFF 01", out_imm_ext, out_type);
        end
        checks++;
        if (w_imm_ext !== 64'h000000000000FFFF) begin
            failures++;
            $display("[TB] FAIL ori_imm64: got %h expected 000000000000FFFF", w_imm_ext);
        end
        next_cycle();
    endtask

    task automatic test_jtype;
        present(32'h0C100010, 32'h20);
        checks++;
        if (out_type !== 2'b10 || out_jtarget !== 26'h0100010 || out_opcode !== 6'h03) begin
            failures++;
            $display("[TB] FAIL jal_fields: got type=%b jt=%h op=%h expected 10 0100010 03", out_type, out_jtarget, out_opcode);
        end
        next_cycle();
    endtask

    task automatic test_backpressure;
        drive(1'b1, 32'h014B4820, 32'h100, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 32'h2108FFFF, 32'h104, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 32'h0C100010, 32'h108, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h100) begin
                failures++;
                $display("[TB] FAIL bp_full: got ready=%b valid=%b pc=%h expected 0 1 100", in_ready, out_valid, out_pc);
            end
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_pc !== 32'h100 || out_opcode !== 6'h00) begin
            failures++;
            $display("[TB] FAIL bp_first: got pc=%h op=%h expected 100 00", out_pc, out_opcode);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h104 || out_opcode !== 6'h08 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_second: got valid=%b pc=%h op=%h ready=%b expected 1 104 08 1",
                     out_valid, out_pc, out_opcode, in_ready);
        end
        next_cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h108 || out_opcode !== 6'h03) begin
            failures++;
            $display("[TB] FAIL bp_third: got valid=%b pc=%h op=%h expected 1 108 03", out_valid, out_pc, out_opcode);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_empty: got valid=%b expected 0", out_valid);
        end
        next_cycle();
    endtask

    task automatic test_flush;
        drive(1'b1, 32'h014B4820, 32'h300, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 32'h2108FFFF, 32'h304, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 32'h3408FFFF, 32'h308, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush_setup: got ready=%b valid=%b expected 0 1", in_ready, out_valid);
        end
        next_cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL flush_two: got valid=%b ready=%b pc=%h expected 0 1", out_valid, in_ready, out_pc);
            end
            next_cycle();
        end
        drive(1'b1, 32'h014B4820, 32'h400, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 32'h2108FFFF, 32'h404, 1'b1, 1'b1);
        next_cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush_one: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
        end
        next_cycle();
    endtask

    task automatic test_midreset;
        drive(1'b1, 32'h014B4820, 32'h500, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 32'h3408FFFF, 32'h504, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || w_out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_hs: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
        end
        checks++;
        if ({out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct, out_imm_ext, out_jtarget, out_type, out_pc, w_imm_ext} !== '0) begin
            failures++;
            $display("[TB] FAIL midreset_fields: got pc=%h imm=%h expected all zero", out_pc, out_imm_ext);
        end
        next_cycle();
        rst_n = 1'b1;
        drive(1'b1, 32'h014B4820, 32'h200, 1'b1, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_funct !== 6'h20) begin
            failures++;
            $display("[TB] FAIL midreset_first: got valid=%b pc=%h fn=%h expected 1 200 20", out_valid, out_pc, out_funct);
        end
        next_cycle();
    endtask

    task automatic test_random;
        logic [31:0] q_instr[$];
        logic [31:0] q_pc[$];
        logic [31:0] ins, pc, e;
        logic        v, ordy, fl, pop, push;
        logic [63:0] e_imm;
        for (int n = 0; n < 3000; n++) begin
            v    = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 39) == 0);
            ins  = $urandom;
            pc   = $urandom;
            case ($urandom_range(0, 5))
                0: ins[31:26] = 6'h00;
                1: ins[31:26] = 6'(2 + $urandom_range(0, 1));
                2: ins[31:26] = 6'(12 + $urandom_range(0, 2));
                3: ins[31:26] = 6'h08;
                default: ;
            endcase
            drive(v, ins, pc, ordy, fl);
            @(negedge clk);
            checks++;
            if (out_valid !== (q_instr.size() > 0) || in_ready !== (q_instr.size() < 2)) begin
                failures++;
                $display("[TB] FAIL rand_hs: got valid=%b ready=%b expected occupancy %0d", out_valid, in_ready, q_instr.size());
            end
            if (q_instr.size() > 0) begin
                e     = q_instr[0];
                e_imm = ref_imm(e);
                checks++;
                if (out_opcode !== 6'(e >> 26) || out_rs !== 5'((e >> 21) & 31) || out_rt !== 5'((e >> 16) & 31) ||
                    out_rd !== 5'((e >> 11) & 31) || out_shamt !== 5'((e >> 6) & 31) || out_funct !== 6'(e & 63) ||
                    out_jtarget !== 26'(e & 32'h03FFFFFF) || out_type !== ref_type(e)) begin
                    failures++;
                    $display("[TB] FAIL rand_fields: got op=%h type=%b jt=%h expected from instr %h",
                             out_opcode, out_type, out_jtarget, e);
                end
                checks++;
                if (out_imm_ext !== 32'(e_imm) || w_imm_ext !== e_imm || out_pc !== q_pc[0]) begin
                    failures++;
                    $display("[TB] FAIL rand_imm_pc: got imm=%h imm64=%h pc=%h expected %h %h %h",
                             out_imm_ext, w_imm_ext, out_pc, 32'(e_imm), e_imm, q_pc[0]);
                end
            end
            pop  = (q_instr.size() > 0) && ordy;
            push = v && (q_instr.size() < 2) && !fl;
            next_cycle();
            if (pop) begin
                void'(q_instr.pop_front());
                void'(q_pc.pop_front());
            end
            if (fl) begin
                q_instr.delete();
                q_pc.delete();
            end else if (push) begin
                q_instr.push_back(ins);
                q_pc.push_back(pc);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        next_cycle();
        next_cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_rtype();
        test_imm();
        test_jtype();
        test_backpressure();
        test_flush();
        test_midreset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: got no completion expected finish before 500000");
        $fatal(1, "[TB] timeout");
    end

endmodule
